// File: rtl/dff_pipe.sv
// Valid/ready pipeline register chain with bubble collapse and synchronous flush.
// Each stage moves forward whenever it is empty or the stage ahead is moving.
module dff_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] rdy;

  function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] bits);
    logic [OCC_W-1:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n = n + OCC_W'(bits[i]);
    end
    return n;
  endfunction

  // Ready ripples back from the output: a stage can load if it is empty
  // or everything ahead of it is able to move.
  always_comb begin : ready_chain
    logic r;
    r   = out_ready;
    rdy = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      r      = ~vld[i] | r;
      rdy[i] = r;
    end
  end

  assign in_ready = rdy[0] & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data[i] <= RST_VAL;
      end
    end else if (flush) begin
      vld <= '0;
    end else begin
      if (rdy[0]) begin
        vld[0] <= in_valid;
        if (in_valid) data[0] <= in_data;
      end
      // Bubbles advance the valid bit only; held data stays put.
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          vld[i] <= vld[i-1];
          if (vld[i-1]) data[i] <= data[i-1];
        end
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = data[DEPTH-1];
  assign occupancy = popcount(vld);

`ifndef SYNTHESIS
  a_out_stable: assert property (@(posedge clk) disable iff (!rst)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

  a_occ_range: assert property (@(posedge clk) disable iff (!rst)
    occupancy <= OCC_W'(DEPTH));
`endif

endmodule
